// File: rtl/duc_pkg.sv
// +----------------------------------------------------------------------------+
// | duc_pkg : shared DUC constants, pack FSM states and DW saturation helper   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package duc_pkg;

  localparam int DUC_DW     = 16;
  localparam int DUC_GFRAC  = 14;
  // Wide enough for a DW x DW product plus one rounding carry bit.
  localparam int DUC_SAT_IW = 2*DUC_DW + 1;

  localparam logic signed [DUC_SAT_IW-1:0] DUC_SAT_MAX = DUC_SAT_IW'((2**(DUC_DW-1)) - 1);
  localparam logic signed [DUC_SAT_IW-1:0] DUC_SAT_MIN = DUC_SAT_IW'(-(2**(DUC_DW-1)));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } pack_state_e;

  function automatic logic signed [DUC_DW-1:0] sat_dw(input logic signed [DUC_SAT_IW-1:0] x);
    logic signed [DUC_DW-1:0] r;
    if (x > DUC_SAT_MAX)      r = DUC_SAT_MAX[DUC_DW-1:0];
    else if (x < DUC_SAT_MIN) r = DUC_SAT_MIN[DUC_DW-1:0];
    else                      r = x[DUC_DW-1:0];
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/duc_gain_sat.sv
// +----------------------------------------------------------------------------+
// | duc_gain_sat : 2-stage signed multiply, round-half-up and saturate pipe    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module duc_gain_sat
  import duc_pkg::*;
#(
  parameter int DW    = DUC_DW,
  parameter int GW    = 16,
  parameter int GFRAC = DUC_GFRAC
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_enable,
  input  logic          i_vld,
  input  logic          i_ca,
  input  logic [DW-1:0] i_data,
  input  logic [GW-1:0] i_gain,
  output logic          o_vld,
  output logic          o_ca,
  output logic [DW-1:0] o_data
);

  localparam int c_PW = DW + GW;
  localparam logic signed [DUC_SAT_IW-1:0] c_HALF = DUC_SAT_IW'(1) <<< (GFRAC - 1);

  logic signed [c_PW-1:0]       w_prod;
  logic signed [DUC_SAT_IW-1:0] w_rnd;
  logic signed [DW-1:0]         w_sat;

  logic signed [c_PW-1:0] r_prod;
  logic                   r_s1_vld;
  logic                   r_s1_ca;
  logic signed [DW-1:0]   r_s2_d;
  logic                   r_s2_vld;
  logic                   r_s2_ca;

  assign w_prod = $signed(i_data) * $signed(i_gain);
  // Sign-extend before adding the half-LSB so the shift is a floor of the rounded value.
  assign w_rnd  = (DUC_SAT_IW'(r_prod) + c_HALF) >>> GFRAC;
  assign w_sat  = sat_dw(w_rnd);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_prod   <= '0;
      r_s1_vld <= 1'b0;
      r_s1_ca  <= 1'b0;
      r_s2_d   <= '0;
      r_s2_vld <= 1'b0;
      r_s2_ca  <= 1'b0;
    end else if (!i_enable) begin
      r_s1_vld <= 1'b0;
      r_s1_ca  <= 1'b0;
      r_s2_vld <= 1'b0;
      r_s2_ca  <= 1'b0;
    end else begin
      r_prod   <= w_prod;
      r_s1_vld <= i_vld;
      r_s1_ca  <= i_vld & i_ca;
      r_s2_d   <= w_sat;
      r_s2_vld <= r_s1_vld;
      r_s2_ca  <= r_s1_ca;
    end
  end

  assign o_vld  = r_s2_vld;
  assign o_ca   = r_s2_ca;
  assign o_data = r_s2_d;

endmodule

`default_nettype wire

// File: rtl/duc_gain_pack.sv
// +----------------------------------------------------------------------------+
// | duc_gain_pack : gain/saturate then pack ca-aligned sample pairs to 2*DW   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module duc_gain_pack
  import duc_pkg::*;
#(
  parameter int DW    = DUC_DW,
  parameter int GW    = 16,
  parameter int GFRAC = DUC_GFRAC,
  parameter int ECW   = 8
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_data_vld,
  input  logic            i_data_ca,
  input  logic [DW-1:0]   i_data,
  input  logic [GW-1:0]   i_gain,
  input  logic            i_enable,
  output logic            o_pack_vld,
  output logic            o_pack_ca,
  output logic [2*DW-1:0] o_pack_data,
  output logic            o_align_err,
  output logic [ECW-1:0]  o_err_cnt
);

  localparam logic [1:0]     c_S_IDLE  = ST_IDLE;
  localparam logic [1:0]     c_S_LOW   = ST_LOW;
  localparam logic [1:0]     c_S_HIGH  = ST_HIGH;
  localparam logic [ECW-1:0] c_CNT_MAX = {ECW{1'b1}};

  logic          w_s2_vld;
  logic          w_s2_ca;
  logic [DW-1:0] w_s2_d;

  logic [1:0]      r_state;
  logic [DW-1:0]   r_low;
  logic            r_low_ca;
  logic            r_pack_vld;
  logic            r_pack_ca;
  logic [2*DW-1:0] r_pack_data;
  logic            r_align_err;
  logic [ECW-1:0]  r_err_cnt;

  duc_gain_sat #(
    .DW    (DW),
    .GW    (GW),
    .GFRAC (GFRAC)
  ) u_gain_sat (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_enable (i_enable),
    .i_vld    (i_data_vld),
    .i_ca     (i_data_ca),
    .i_data   (i_data),
    .i_gain   (i_gain),
    .o_vld    (w_s2_vld),
    .o_ca     (w_s2_ca),
    .o_data   (w_s2_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_S_IDLE;
      r_low       <= '0;
      r_low_ca    <= 1'b0;
      r_pack_vld  <= 1'b0;
      r_pack_ca   <= 1'b0;
      r_pack_data <= '0;
      r_align_err <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_pack_vld  <= 1'b0;
      r_align_err <= 1'b0;
      if (!i_enable) begin
        r_state <= c_S_IDLE;
      end else if (w_s2_vld) begin
        case (r_state)
          c_S_IDLE: begin
            if (w_s2_ca) begin
              r_low    <= w_s2_d;
              r_low_ca <= 1'b1;
              r_state  <= c_S_HIGH;
            end
          end
          c_S_LOW: begin
            r_low    <= w_s2_d;
            r_low_ca <= w_s2_ca;
            r_state  <= c_S_HIGH;
          end
          c_S_HIGH: begin
            if (!w_s2_ca) begin
              r_pack_data <= {w_s2_d, r_low};
              r_pack_ca   <= r_low_ca;
              r_pack_vld  <= 1'b1;
              r_state     <= c_S_LOW;
            end else begin
              // A new frame start while half a word is pending: restart the pair on it.
              r_align_err <= 1'b1;
              if (r_err_cnt != c_CNT_MAX) r_err_cnt <= r_err_cnt + 1'b1;
              r_low    <= w_s2_d;
              r_low_ca <= 1'b1;
            end
          end
          default: r_state <= c_S_IDLE;
        endcase
      end
    end
  end

  assign o_pack_vld  = r_pack_vld;
  assign o_pack_ca   = r_pack_ca;
  assign o_pack_data = r_pack_data;
  assign o_align_err = r_align_err;
  assign o_err_cnt   = r_err_cnt;

endmodule

`default_nettype wire

// File: tb/tb_duc_gain_pack.sv
// +----------------------------------------------------------------------------+
// | tb_duc_gain_pack : randomized + directed bench with sample-level model    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_duc_gain_pack;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_data_vld;
  logic        i_data_ca;
  logic [15:0] i_data;
  logic [15:0] i_gain;
  logic        i_enable;
  logic        o_pack_vld;
  logic        o_pack_ca;
  logic [31:0] o_pack_data;
  logic        o_align_err;
  logic [7:0]  o_err_cnt;

  always #5 i_clk = ~i_clk;

  duc_gain_pack dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_data_vld  (i_data_vld),
    .i_data_ca   (i_data_ca),
    .i_data      (i_data),
    .i_gain      (i_gain),
    .i_enable    (i_enable),
    .o_pack_vld  (o_pack_vld),
    .o_pack_ca   (o_pack_ca),
    .o_pack_data (o_pack_data),
    .o_align_err (o_align_err),
    .o_err_cnt   (o_err_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: each accepted sample reaches the pairing logic two edges after capture.
  typedef struct {
    int          due;
    logic [15:0] v;
    bit          ca;
  } inflight_t;

  inflight_t   q[$];
  int          cyc = 0;
  bit          synced, have_low, low_ca;
  logic [15:0] low;
  bit          e_vld, e_ca, e_err;
  logic [31:0] e_data;
  int          e_cnt;

  int          words = 0;
  int          errs  = 0;
  logic [31:0] last_word = '0;
  bit          last_ca   = 1'b0;

  function automatic logic [15:0] gain_model(logic [15:0] d, logic [15:0] g);
    longint p, r;
    p = longint'($signed(d)) * longint'($signed(g));
    r = (p + 8192) >>> 14;
    if (r > 32767)  r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic model_sample(logic [15:0] v, bit ca);
    if (ca) begin
      if (have_low) begin
        e_err = 1'b1;
        if (e_cnt < 255) e_cnt++;
      end
      have_low = 1'b1; low = v; low_ca = 1'b1; synced = 1'b1;
    end else if (have_low) begin
      e_vld = 1'b1; e_data = {v, low}; e_ca = low_ca; have_low = 1'b0;
    end else if (synced) begin
      have_low = 1'b1; low = v; low_ca = 1'b0;
    end
  endtask

  task automatic model_step();
    inflight_t it;
    cyc++;
    if (i_rst) begin
      q.delete();
      synced = 0; have_low = 0; low_ca = 0; low = '0;
      e_vld = 0; e_ca = 0; e_err = 0; e_data = '0; e_cnt = 0;
      return;
    end
    e_vld = 0; e_err = 0;
    if (!i_enable) begin
      q.delete();
      synced = 0; have_low = 0;
      return;
    end
    while (q.size() > 0 && q[0].due == cyc) begin
      it = q.pop_front();
      model_sample(it.v, it.ca);
    end
    if (i_data_vld) begin
      it.due = cyc + 2; it.v = gain_model(i_data, i_gain); it.ca = i_data_ca;
      q.push_back(it);
    end
  endtask

  task automatic chk(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    chk("pack_vld",  o_pack_vld,  e_vld);
    chk("pack_ca",   o_pack_ca,   e_ca);
    chk("pack_data", o_pack_data, e_data);
    chk("align_err", o_align_err, e_err);
    chk("err_cnt",   o_err_cnt,   e_cnt);
    if (o_pack_vld) begin
      words++; last_word = o_pack_data; last_ca = o_pack_ca;
    end
    if (o_align_err) errs++;
  endtask

  task automatic tick();
    @(posedge i_clk);
    model_step();
    #1;
    compare();
  endtask

  task automatic send(logic [15:0] d, logic [15:0] g, bit ca);
    i_data_vld = 1'b1; i_data = d; i_gain = g; i_data_ca = ca;
    tick();
  endtask

  task automatic idle(int n);
    i_data_vld = 1'b0; i_data_ca = 1'b0;
    for (int k = 0; k < n; k++) tick();
  endtask

  int w0, e0, c0;

  initial begin
    i_rst = 1'b1; i_enable = 1'b1; i_data_vld = 1'b0; i_data_ca = 1'b0;
    i_data = '0; i_gain = 16'h4000;
    idle(3);
    chk("rst_pack_data", o_pack_data, 0);
    chk("rst_err_cnt",   o_err_cnt,   0);
    i_rst = 1'b0;
    idle(2);

    // Unity gain pair, latency: output on the third edge after the second sample.
    send(16'h0100, 16'h4000, 1'b1);
    send(16'h0200, 16'h4000, 1'b0);
    idle(1);
    chk("t1_vld_early", o_pack_vld, 0);
    idle(1);
    chk("t1_vld",  o_pack_vld,  1);
    chk("t1_word", o_pack_data, 32'h02000100);
    chk("t1_ca",   o_pack_ca,   1);
    idle(2);

    // Saturation both directions.
    w0 = words;
    send(16'h7FFF, 16'h7FFF, 1'b1);
    send(16'h8000, 16'h7FFF, 1'b0);
    idle(3);
    chk("sat_words", words - w0, 1);
    chk("sat_word",  last_word, 32'h80007FFF);

    // Rounding at gain 0.5.
    send(16'h0003, 16'h2000, 1'b1);
    send(16'hFFFD, 16'h2000, 1'b0);
    idle(3);
    chk("rnd_word", last_word, 32'hFFFF0002);

    // Misalignment A(ca), B(ca), C.
    w0 = words; e0 = errs; c0 = int'(o_err_cnt);
    send(16'h1111, 16'h4000, 1'b1);
    send(16'h2222, 16'h4000, 1'b1);
    send(16'h3333, 16'h4000, 1'b0);
    idle(3);
    chk("mis_errs",  errs - e0, 1);
    chk("mis_cnt",   o_err_cnt, c0 + 1);
    chk("mis_words", words - w0, 1);
    chk("mis_word",  last_word, 32'h33332222);
    chk("mis_ca",    last_ca, 1);

    // Flush to IDLE, then plain samples must be discarded until a ca arrives.
    i_enable = 1'b0; idle(1); i_enable = 1'b1;
    w0 = words;
    for (int k = 0; k < 5; k++) send(16'(k + 5), 16'h4000, 1'b0);
    idle(3);
    chk("noca_words", words - w0, 0);
    send(16'h0010, 16'h4000, 1'b1);
    send(16'h0020, 16'h4000, 1'b0);
    idle(3);
    chk("noca_pair_words", words - w0, 1);
    chk("noca_pair_word",  last_word, 32'h00200010);

    // Reset one cycle after a ca sample.
    w0 = words;
    send(16'h0400, 16'h4000, 1'b1);
    i_rst = 1'b1; idle(1); i_rst = 1'b0;
    idle(3);
    chk("rst_mid_words", words - w0, 0);
    send(16'h0500, 16'h4000, 1'b1);
    send(16'h0600, 16'h4000, 1'b0);
    idle(3);
    chk("rst_after_words", words - w0, 1);
    chk("rst_after_word",  last_word, 32'h06000500);
    chk("rst_after_ca",    last_ca, 1);

    // Disable one cycle after a ca sample; the sample presented while disabled is lost.
    w0 = words;
    send(16'h0700, 16'h4000, 1'b1);
    i_enable = 1'b0; send(16'h0800, 16'h4000, 1'b0); i_enable = 1'b1;
    idle(3);
    chk("dis_mid_words", words - w0, 0);
    send(16'h0900, 16'h4000, 1'b1);
    send(16'h0A00, 16'h4000, 1'b0);
    idle(3);
    chk("dis_after_word", last_word, 32'h0A000900);
    chk("dis_after_ca",   last_ca, 1);

    // Randomized traffic.
    for (int k = 0; k < 3000; k++) begin
      i_rst      = ($urandom_range(0, 399) == 0);
      i_enable   = ($urandom_range(0, 49) != 0);
      i_data_vld = ($urandom_range(0, 3) != 0);
      i_data_ca  = ($urandom_range(0, 4) == 0);
      i_data     = 16'($urandom);
      i_gain     = ($urandom_range(0, 3) == 0) ? 16'h4000 : 16'($urandom);
      tick();
    end
    i_rst = 1'b0; i_enable = 1'b1;
    idle(4);

    // Counter saturation: 300 back-to-back ca samples.
    for (int k = 0; k < 300; k++) send(16'(k), 16'h4000, 1'b1);
    idle(3);
    chk("cnt_sat", o_err_cnt, 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
